morse_digit_decoder: RTL and testbench
======================================

# morse_digit_decoder

Receive side of the Morse digit path: decodes a hand-keyed Morse character back into a BCD digit 0–9. It turns a single key line (pushbutton/switch) into dot/dash symbols by timing each press, and collects up to five symbols. The character ends on an inter-character gap, and the block then emits the digit or an error. The pattern bit order matches the encoder's d5..d1 output, so the two blocks can be looped back on the board.

## Interface
Parameters:
- `DEBOUNCE`, 250000 – minimum press length in cycles; shorter presses are glitches.
- `DASH_MIN`, 10000000 – press length ≥ this is a dash, otherwise a dot.
- `GAP`, 25000000 – continuous release length in cycles that ends a character.
- `LONG_MAX`, 100000000 – press length at which the key is declared stuck.
- `CW`, 27 – timer width; must hold `LONG_MAX`.

Ports:
- `clk`  in  1  – single clock; the block uses no other clock.
- `reset_n`  in  1  – synchronous, active-low reset.
- `key`  in  1  – asynchronous key level, 1 = pressed.
- `digit`  out  4  – last decoded BCD digit.
- `pattern`  out  5  – last complete pattern; bit4 = first symbol (d5), bit0 = fifth (d1); 1 = dash.
- `valid`  out  1  – one-cycle pulse: `digit`/`pattern` updated.
- `error`  out  1  – one-cycle pulse: character rejected.
- `busy`  out  1  – high whenever the state is not IDLE.

## Operation
- `key` passes through a 2-flop synchronizer to give `key_s`.
- State machine: IDLE, PRESS, GAP, DRAIN.
  - IDLE: on `key_s` = 1, go to PRESS with timer = 1.
  - PRESS: timer increments each cycle.
    - Timer reaches `LONG_MAX`: pulse `error`, go to DRAIN.
    - On release with timer < `DEBOUNCE`: glitch; return to IDLE if sym_cnt = 0, else to GAP with timer = 0. The glitch is not counted.
    - On release with timer ≥ `DEBOUNCE`: classify as dot or dash. If sym_cnt = 5, pulse `error` and go to DRAIN. Otherwise shift the symbol into the shift register at bit (4 − sym_cnt), increment sym_cnt, and go to GAP with timer = 0.
  - GAP: timer increments each cycle.
    - On `key_s` = 1: go to PRESS with timer = 1.
    - Timer reaches `GAP`: evaluate the character and go to IDLE.
  - Evaluation:
    - sym_cnt = 5 and the shift register holds a legal pattern: load `pattern` and `digit`, pulse `valid`.
    - Otherwise pulse `error`; `digit` and `pattern` hold their old values.
  - DRAIN: discards the rest of a bad character. The timer clears while `key_s` = 1 and counts while it is 0. When the timer reaches `GAP`, go to IDLE.
  - On every entry to IDLE, clear the shift register and sym_cnt.
- Legal patterns:
  - 1 = 01111, 2 = 00111, 3 = 00011, 4 = 00001, 5 = 00000.
  - 6 = 10000, 7 = 11000, 8 = 11100, 9 = 11110, 0 = 11111.
- Timers saturate and never wrap.

## Timing
- Reset values: `digit` = 0, `pattern` = 0, `valid` = 0, `error` = 0, `busy` = 0, state IDLE, sync flops 0.
- Reset at any point, including mid-character or during DRAIN, discards the partial character with no pulse.
- Input latency is 2 cycles from `key` to `key_s`.
- `valid`/`error` are registered and assert in the cycle after the deciding event (timer = `GAP`, release, or timer = `LONG_MAX`). Each is high for exactly 1 cycle.
- `valid` and `error` are never high together.
- `digit`/`pattern` change only in the same cycle as `valid`.
- A press that starts in the same cycle the GAP timer reaches `GAP`: the evaluation wins and the press is seen from IDLE on the next cycle. A key held across this boundary therefore starts a new character.

## Structure
- Shared include `morse_defs.vh` holds:
  - the ten legal 5-bit patterns;
  - the DOT = 0 / DASH = 1 encoding;
  - the state encodings.
- The encoder uses the same include.
- One sub-module, `morse_key_sync`: the 2-flop synchronizer with a synchronous active-low reset.
- Pattern-to-digit lookup is a function in the top-level module.

## Test plan
All scenarios use `DEBOUNCE` = 2, `DASH_MIN` = 8, `GAP` = 16, `LONG_MAX` = 40. Dot = 4-cycle press, dash = 10-cycle press, intra-character release = 4 cycles.

1. Hold `reset_n` = 0 for 3 cycles while `key` toggles → all outputs 0, `busy` = 0.
2. Key dot, dash, dash, dash, dash, then release 20 cycles → single `valid` pulse, `digit` = 1, `pattern` = 01111. Then key 5 dots → `valid`, `digit` = 5, `pattern` = 00000.
3. Key 3 dots, then release 20 cycles → single `error` pulse, no `valid`, `digit` remains 5.
4. Key 6 dashes → `error` pulses after the 6th release. DRAIN then absorbs a 7th dash. `busy` falls 16 cycles after the last release, and no `valid` is seen.
5. Key 1-cycle glitches between dashes of "-----" → glitches are ignored, and the result is `valid` with `digit` = 0 and `pattern` = 11111.
6. Hold the key for 50 cycles → `error` at timer 40, and `busy` stays high until 16 cycles after release. Separately, assert reset after 2 symbols → no pulse, and the next full character "--..." decodes to 7.

Source files
------------

// File: rtl/morse_digit_decoder_pkg.sv
// morse_digit_decoder_pkg: shared symbol encoding, legal digit patterns and decoder states
package morse_digit_decoder_pkg;

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_DRAIN} state_e;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam logic [4:0] PAT_0 = 5'b11111;
    localparam logic [4:0] PAT_1 = 5'b01111;
    localparam logic [4:0] PAT_2 = 5'b00111;
    localparam logic [4:0] PAT_3 = 5'b00011;
    localparam logic [4:0] PAT_4 = 5'b00001;
    localparam logic [4:0] PAT_5 = 5'b00000;
    localparam logic [4:0] PAT_6 = 5'b10000;
    localparam logic [4:0] PAT_7 = 5'b11000;
    localparam logic [4:0] PAT_8 = 5'b11100;
    localparam logic [4:0] PAT_9 = 5'b11110;

endpackage

// File: rtl/morse_key_sync.sv
// morse_key_sync: two-flop synchronizer for the asynchronous key line
module morse_key_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic key_i,
    output logic key_s_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[0], key_i};
    end

    assign key_s_o = sync_q[1];

endmodule

// File: rtl/morse_digit_decoder.sv
// morse_digit_decoder: times key presses into dots/dashes and decodes a 5-symbol character to BCD
module morse_digit_decoder
    import morse_digit_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 250000,
    parameter int unsigned DASH_MIN = 10000000,
    parameter int unsigned GAP      = 25000000,
    parameter int unsigned LONG_MAX = 100000000,
    parameter int          CW       = 27
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key,
    output logic [3:0] digit,
    output logic [4:0] pattern,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    localparam logic [CW-1:0] T_DEB  = CW'(DEBOUNCE);
    localparam logic [CW-1:0] T_DASH = CW'(DASH_MIN);
    localparam logic [CW-1:0] T_GAP  = CW'(GAP);
    localparam logic [CW-1:0] T_LONG = CW'(LONG_MAX);

    // {legal, digit}; legal = 0 for any pattern outside the ten digits
    function automatic logic [4:0] lookup(input logic [4:0] p);
        case (p)
            PAT_0:   return {1'b1, 4'd0};
            PAT_1:   return {1'b1, 4'd1};
            PAT_2:   return {1'b1, 4'd2};
            PAT_3:   return {1'b1, 4'd3};
            PAT_4:   return {1'b1, 4'd4};
            PAT_5:   return {1'b1, 4'd5};
            PAT_6:   return {1'b1, 4'd6};
            PAT_7:   return {1'b1, 4'd7};
            PAT_8:   return {1'b1, 4'd8};
            PAT_9:   return {1'b1, 4'd9};
            default: return 5'b0;
        endcase
    endfunction

    logic          key_s;
    state_e        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d, timer_inc;
    logic [4:0]    shift_q, shift_d, pattern_q, pattern_d, hit;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    digit_q, digit_d;
    logic          valid_q, valid_d, error_q, error_d, sym;

    morse_key_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .key_i   (key),
        .key_s_o (key_s)
    );

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + CW'(1);
    assign sym       = (timer_q >= T_DASH) ? DASH : DOT;
    assign hit       = lookup(shift_q);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_inc;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        digit_d   = digit_q;
        pattern_d = pattern_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = key_s ? S_PRESS : S_IDLE;
                timer_d = key_s ? CW'(1) : '0;
            end
            S_PRESS: begin
                if (timer_q == T_LONG) begin
                    error_d = 1'b1;
                    state_d = S_DRAIN;
                    timer_d = '0;
                end else if (!key_s) begin
                    timer_d = '0;
                    if (timer_q < T_DEB) begin
                        state_d = (cnt_q == 3'd0) ? S_IDLE : S_GAP;
                    end else if (cnt_q == 3'd5) begin
                        error_d = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        shift_d[3'd4 - cnt_q] = sym;
                        cnt_d   = cnt_q + 3'd1;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                // evaluation has priority over a press starting in the same cycle
                if (timer_q == T_GAP) begin
                    state_d = S_IDLE;
                    if (cnt_q == 3'd5 && hit[4]) begin
                        valid_d   = 1'b1;
                        digit_d   = hit[3:0];
                        pattern_d = shift_q;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (key_s) begin
                    state_d = S_PRESS;
                    timer_d = CW'(1);
                end
            end
            S_DRAIN: begin
                if (key_s)                 timer_d = '0;
                else if (timer_q == T_GAP) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) begin
            shift_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            digit_q   <= '0;
            pattern_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            pattern_q <= pattern_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign digit   = digit_q;
    assign pattern = pattern_q;
    assign valid   = valid_q;
    assign error   = error_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_morse_digit_decoder.sv
// tb_morse_digit_decoder: table-driven character checks plus hand-timed corner sequences
module tb_morse_digit_decoder;

    typedef struct {
        string      name;
        int         n;
        logic [4:0] syms;
        logic       exp_v;
        logic [3:0] exp_d;
        logic [4:0] exp_p;
    } vec_t;

    logic       clk = 1'b0, reset_n = 1'b0, key = 1'b0;
    logic [3:0] digit;
    logic [4:0] pattern;
    logic       valid, error, busy;
    logic [3:0] prev_d;
    logic [4:0] prev_p;
    int         checks = 0, errors = 0, vcnt = 0, ecnt = 0;
    int         v0, e0, lat;
    vec_t       vecs[7];

    morse_digit_decoder #(
        .DEBOUNCE (2),
        .DASH_MIN (8),
        .GAP      (16),
        .LONG_MAX (40),
        .CW       (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .key     (key),
        .digit   (digit),
        .pattern (pattern),
        .valid   (valid),
        .error   (error),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (valid) vcnt++;
            if (error) ecnt++;
            checks++;
            if (valid && error) begin
                errors++;
                $display("FAIL excl: valid=%0b error=%0b, required never both", valid, error);
            end
            if (!valid && (digit != prev_d || pattern != prev_p)) begin
                errors++;
                $display("FAIL hold: digit %0d->%0d pattern %b->%b without valid", prev_d, digit, prev_p, pattern);
            end
        end
        prev_d = digit;
        prev_p = pattern;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        key = 1'b1;
        repeat (n) @(negedge clk);
        key = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int n, input logic [4:0] s);
        for (int i = 0; i < n; i++) begin
            hold(s[4-i] ? 10 : 4);
            if (i < n - 1) idle(4);
        end
    endtask

    task automatic wait_idle(input string name);
        int l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (busy && l < 100);
        if (busy) chk({name, ".busy_timeout"}, 1, 0);
        idle(3);
        #1;
    endtask

    task automatic results(input string name, input logic ev, input logic [3:0] ed, input logic [4:0] ep);
        chk({name, ".valid_cnt"}, vcnt - v0, int'(ev));
        chk({name, ".error_cnt"}, ecnt - e0, int'(!ev));
        chk({name, ".digit"}, int'(digit), int'(ed));
        chk({name, ".pattern"}, int'(pattern), int'(ep));
    endtask

    task automatic measure(input int which, input int bound, output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (l < bound && (which == 0 ? !valid : which == 1 ? !error : busy));
    endtask

    initial begin
        vecs[0] = '{"one",        5, 5'b01111, 1'b1, 4'd1, 5'b01111};
        vecs[1] = '{"five",       5, 5'b00000, 1'b1, 4'd5, 5'b00000};
        vecs[2] = '{"three_dots", 3, 5'b00000, 1'b0, 4'd5, 5'b00000};
        vecs[3] = '{"nine",       5, 5'b11110, 1'b1, 4'd9, 5'b11110};
        vecs[4] = '{"three",      5, 5'b00011, 1'b1, 4'd3, 5'b00011};
        vecs[5] = '{"illegal",    5, 5'b01010, 1'b0, 4'd3, 5'b00011};
        vecs[6] = '{"six",        5, 5'b10000, 1'b1, 4'd6, 5'b10000};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            key = ~key;
        end
        chk("rst.digit",   int'(digit),   0);
        chk("rst.pattern", int'(pattern), 0);
        chk("rst.valid",   int'(valid),   0);
        chk("rst.error",   int'(error),   0);
        chk("rst.busy",    int'(busy),    0);
        key = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(4);

        foreach (vecs[i]) begin
            v0 = vcnt;
            e0 = ecnt;
            send(vecs[i].n, vecs[i].syms);
            wait_idle(vecs[i].name);
            results(vecs[i].name, vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_p);
        end

        // 2 sync cycles + release decode + 16-cycle gap + registered pulse = 20
        v0 = vcnt; e0 = ecnt;
        send(5, 5'b00001);
        measure(0, 40, lat);
        chk("four.latency", lat, 20);
        @(negedge clk);
        chk("four.width", int'(valid), 0);
        wait_idle("four");
        results("four", 1'b1, 4'd4, 5'b00001);

        v0 = vcnt; e0 = ecnt;
        hold(1);
        idle(3);
        for (int i = 0; i < 5; i++) begin
            hold(10);
            if (i < 4) begin
                idle(2);
                hold(1);
                idle(2);
            end
        end
        wait_idle("glitch");
        results("glitch", 1'b1, 4'd0, 5'b11111);

        v0 = vcnt; e0 = ecnt;
        for (int i = 0; i < 6; i++) begin
            hold(10);
            if (i < 5) idle(4);
        end
        measure(1, 10, lat);
        chk("six_dash.err_latency", lat, 3);
        idle(4);
        hold(10);
        measure(2, 40, lat);
        chk("six_dash.busy_fall", lat, 19);
        idle(3);
        #1;
        results("six_dash", 1'b0, 4'd0, 5'b11111);

        v0 = vcnt; e0 = ecnt;
        key = 1'b1;
        measure(1, 60, lat);
        chk("long.err_latency", lat, 43);
        idle(50 - lat);
        key = 1'b0;
        measure(2, 40, lat);
        chk("long.busy_fall", lat, 19);
        idle(3);
        #1;
        results("long", 1'b0, 4'd0, 5'b11111);

        v0 = vcnt; e0 = ecnt;
        hold(10);
        idle(4);
        hold(10);
        idle(2);
        reset_n = 1'b0;
        idle(3);
        chk("midrst.busy",  int'(busy),  0);
        chk("midrst.digit", int'(digit), 0);
        reset_n = 1'b1;
        idle(30);
        #1;
        chk("midrst.valid_cnt", vcnt - v0, 0);
        chk("midrst.error_cnt", ecnt - e0, 0);

        v0 = vcnt; e0 = ecnt;
        send(5, 5'b11000);
        wait_idle("seven");
        results("seven", 1'b1, 4'd7, 5'b11000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
